// File: rtl/mask_tx.sv
`default_nettype none
// ============================================================================
// Module   : mask_tx
// Brief    : M-ary ASK transmitter. Frames are split MSB-first into symbols,
//            and each symbol scales the carrier sample for SYM_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module mask_tx #(
    parameter int DATA_W       = 16,
    parameter int BITS_PER_SYM = 1,
    parameter int SYM_CYCLES   = 50,
    parameter int SINE_W       = 16,
    parameter int IDLE_MODE    = 0
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic signed [SINE_W-1:0]              sine_val,
    input  logic        [DATA_W-1:0]              data_in,
    input  logic                                  data_valid,
    output logic                                  data_ready,
    output logic signed [SINE_W+BITS_PER_SYM-1:0] mod_out,
    output logic        [BITS_PER_SYM-1:0]        level_out,
    output logic                                  sym_start,
    output logic                                  busy
);

    localparam int c_NSYM  = DATA_W / BITS_PER_SYM;
    localparam int c_CYC_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int c_SYM_W = (c_NSYM > 1) ? $clog2(c_NSYM) : 1;
    localparam int c_OUT_W = SINE_W + BITS_PER_SYM;

    localparam logic [c_CYC_W-1:0]      c_CYC_LAST   = c_CYC_W'(SYM_CYCLES - 1);
    localparam logic [c_SYM_W-1:0]      c_SYM_LAST   = c_SYM_W'(c_NSYM - 1);
    localparam logic [BITS_PER_SYM-1:0] c_IDLE_LEVEL = (IDLE_MODE == 0) ? {BITS_PER_SYM{1'b1}}
                                                                          : {BITS_PER_SYM{1'b0}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DATA_W-1:0]         r_shift;
    logic [c_CYC_W-1:0]        r_cyc;
    logic [c_SYM_W-1:0]        r_sym;

    logic                      w_last;
    logic                      w_ready;
    logic                      w_load;
    logic [BITS_PER_SYM-1:0]   w_level;
    logic signed [c_OUT_W-1:0] w_sine_ext;
    logic signed [c_OUT_W-1:0] w_lvl_ext;
    logic signed [c_OUT_W-1:0] w_prod;

    // ------------------------------------------------------------------
    // Control: state register and next-state decode
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_last      = (r_state == S_SEND) && (r_cyc == c_CYC_LAST) && (r_sym == c_SYM_LAST);
        w_ready     = (r_state == S_IDLE) || w_last;
        w_load      = w_ready && data_valid;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_last && !data_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Symbol sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_shift <= '0;
            r_cyc   <= '0;
            r_sym   <= '0;
        end else if (w_load) begin
            r_shift <= data_in;
            r_cyc   <= '0;
            r_sym   <= '0;
        end else if (r_state == S_SEND) begin
            if (r_cyc == c_CYC_LAST) begin
                r_cyc   <= '0;
                r_shift <= r_shift << BITS_PER_SYM;
                // Wrap at end of frame so a non-power-of-two symbol count never overruns
                r_sym   <= w_last ? '0 : r_sym + 1'b1;
            end else begin
                r_cyc   <= r_cyc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Amplitude scaling: the product always fits in SINE_W+BITS_PER_SYM,
    // so computing directly at output width is exact.
    // ------------------------------------------------------------------
    always_comb begin
        w_level    = (r_state == S_SEND) ? r_shift[DATA_W-1 -: BITS_PER_SYM] : c_IDLE_LEVEL;
        w_sine_ext = {{BITS_PER_SYM{sine_val[SINE_W-1]}}, sine_val};
        w_lvl_ext  = $signed({{SINE_W{1'b0}}, w_level});
        w_prod     = w_sine_ext * w_lvl_ext;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mod_out   <= '0;
            level_out <= '0;
            sym_start <= 1'b0;
        end else begin
            mod_out   <= w_prod;
            level_out <= w_level;
            sym_start <= (r_state == S_SEND) && (r_cyc == '0);
        end
    end

    assign data_ready = w_ready;
    assign busy       = (r_state == S_SEND);

endmodule
`default_nettype wire
